// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the SPI command decoder: FSM state codes, command
// byte field positions and the default status byte returned on MISO.
// Optional feature macro used by the bridge: SPI_REG_BRIDGE_AUTOINC_EN.
package spi_reg_bridge_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_CMD     = 3'd1;
   localparam state_t ST_WR      = 3'd2;
   localparam state_t ST_RD_REQ  = 3'd3;
   localparam state_t ST_RD_WAIT = 3'd4;
   localparam state_t ST_RD_DATA = 3'd5;

   // Command byte layout: bit 7 selects read (1) or write (0), bits 6:0 address
   localparam int CMD_RW_BIT   = 7;
   localparam int CMD_ADDR_MSB = 6;
   localparam int CMD_ADDR_LSB = 0;

   localparam logic [7:0] STATUS_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_reg_bridge_cs_sync.sv
// Two-flop synchronizer for the raw SPI chip select, plus edge detection on
// the synchronized value. All flops reset to 1 (deselected), so a chip select
// that is already low when reset releases still produces a falling edge.
module spi_cs_sync (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_SPI_CS_n,
   output logic o_CS_Active,
   output logic o_CS_Rise,
   output logic o_CS_Fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   // Shift chain: raw -> meta -> sync -> prev (prev only feeds edge detect)
   always_comb begin
      meta_d = i_SPI_CS_n;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // Synchronizer and edge-history registers
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign o_CS_Active = ~sync_q;
   assign o_CS_Rise   = sync_q & ~prev_q;
   assign o_CS_Fall   = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI byte-stream to register-bus bridge. The first byte of each chip-select
// window is a command (R/W + start address); following bytes are write data
// or read dummies. Reads return register data on the next MISO byte.
// Every output is registered; o_State exposes the FSM for observation.
// Handshake: i_RX_DV, o_TX_DV, o_Reg_Wr and o_Reg_Rd are single-cycle
// strobes with no back-pressure; the data beside a strobe is valid only in
// the strobe cycle, and i_Reg_RData is sampled exactly one cycle after
// o_Reg_Rd.
// Macro SPI_REG_BRIDGE_AUTOINC_EN: when defined the address advances (and
// wraps) after every data byte; when undefined it stays at the command address.
module spi_reg_bridge
   import spi_reg_bridge_pkg::*;
#(
   parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEFAULT,
   parameter int         ADDR_W      = 7
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              i_SPI_CS_n,
   input  logic              i_RX_DV,
   input  logic [7:0]        i_RX_Byte,
   output logic              o_TX_DV,
   output logic [7:0]        o_TX_Byte,
   output logic              o_Reg_Wr,
   output logic              o_Reg_Rd,
   output logic [ADDR_W-1:0] o_Reg_Addr,
   output logic [7:0]        o_Reg_WData,
   input  logic [7:0]        i_Reg_RData,
   output logic              o_Busy,
   output logic              o_Overrun,
   output state_t            o_State
);

   logic cs_active, cs_rise, cs_fall;

   spi_cs_sync u_cs_sync (
      .i_Clk       (i_Clk),
      .i_Rst       (i_Rst),
      .i_SPI_CS_n  (i_SPI_CS_n),
      .o_CS_Active (cs_active),
      .o_CS_Rise   (cs_rise),
      .o_CS_Fall   (cs_fall)
   );

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              tx_dv_q, tx_dv_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic              reg_wr_q, reg_wr_d;
   logic              reg_rd_q, reg_rd_d;
   logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              overrun_q, overrun_d;
   logic              init_q, init_d;

   // Address used for the next data byte of a burst
   function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
      step_addr = a + ADDR_W'(1);
`else
      step_addr = a;
`endif
   endfunction

   // Next-state and strobe generation; a chip-select release overrides
   // everything so an abandoned transaction emits no register strobes.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      tx_dv_d    = 1'b0;
      tx_byte_d  = tx_byte_q;
      reg_wr_d   = 1'b0;
      reg_rd_d   = 1'b0;
      reg_addr_d = reg_addr_q;
      wdata_d    = wdata_q;
      overrun_d  = overrun_q;
      init_d     = 1'b0;

      // Preload the status byte once after reset so the first command byte
      // already has a defined reply.
      if (init_q) begin
         tx_dv_d   = 1'b1;
         tx_byte_d = STATUS_BYTE;
      end

      if (cs_rise) begin
         state_d   = ST_IDLE;
         tx_dv_d   = 1'b1;
         tx_byte_d = STATUS_BYTE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
               if (i_RX_DV) begin
                  addr_d = i_RX_Byte[ADDR_W-1:0];
                  if (i_RX_Byte[CMD_RW_BIT]) begin
                     // Strobe is registered on entry so RD_REQ holds it
                     reg_rd_d   = 1'b1;
                     reg_addr_d = i_RX_Byte[ADDR_W-1:0];
                     state_d    = ST_RD_REQ;
                  end else begin
                     state_d = ST_WR;
                  end
               end
            end
            ST_WR: begin
               if (i_RX_DV) begin
                  reg_wr_d   = 1'b1;
                  wdata_d    = i_RX_Byte;
                  reg_addr_d = addr_q;
                  addr_d     = step_addr(addr_q);
               end
            end
            ST_RD_REQ: begin
               state_d = ST_RD_WAIT;
               if (i_RX_DV) overrun_d = 1'b1;
            end
            ST_RD_WAIT: begin
               tx_dv_d   = 1'b1;
               tx_byte_d = i_Reg_RData;
               state_d   = ST_RD_DATA;
               if (i_RX_DV) overrun_d = 1'b1;
            end
            ST_RD_DATA: begin
               if (i_RX_DV) begin
                  addr_d     = step_addr(addr_q);
                  reg_addr_d = step_addr(addr_q);
                  reg_rd_d   = 1'b1;
                  state_d    = ST_RD_REQ;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers; reset squashes any strobe in flight
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         tx_dv_q    <= 1'b0;
         tx_byte_q  <= STATUS_BYTE;
         reg_wr_q   <= 1'b0;
         reg_rd_q   <= 1'b0;
         reg_addr_q <= '0;
         wdata_q    <= 8'h00;
         overrun_q  <= 1'b0;
         init_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         tx_dv_q    <= tx_dv_d;
         tx_byte_q  <= tx_byte_d;
         reg_wr_q   <= reg_wr_d;
         reg_rd_q   <= reg_rd_d;
         reg_addr_q <= reg_addr_d;
         wdata_q    <= wdata_d;
         overrun_q  <= overrun_d;
         init_q     <= init_d;
      end
   end

   assign o_TX_DV     = tx_dv_q;
   assign o_TX_Byte   = tx_byte_q;
   assign o_Reg_Wr    = reg_wr_q;
   assign o_Reg_Rd    = reg_rd_q;
   assign o_Reg_Addr  = reg_addr_q;
   assign o_Reg_WData = wdata_q;
   assign o_Busy      = cs_active;
   assign o_Overrun   = overrun_q;
   assign o_State     = state_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: directed table, cycle-exact corner sequences and
// randomized transactions checked against a transaction-level model.
// Honours SPI_REG_BRIDGE_AUTOINC_EN the same way the design does.
module tb_spi_reg_bridge;
   import spi_reg_bridge_pkg::*;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif
   localparam logic [7:0] STATUS = 8'hA5;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       i_Rst = 1'b1;
   logic       i_SPI_CS_n = 1'b1;
   logic       i_RX_DV = 1'b0;
   logic [7:0] i_RX_Byte = 8'h00;
   logic [7:0] i_Reg_RData = 8'h00;
   logic       o_TX_DV, o_Reg_Wr, o_Reg_Rd, o_Busy, o_Overrun;
   logic [7:0] o_TX_Byte, o_Reg_WData;
   logic [6:0] o_Reg_Addr;
   state_t     o_State;

   always #5 clk = ~clk;

   spi_reg_bridge dut (
      .i_Clk       (clk),
      .i_Rst       (i_Rst),
      .i_SPI_CS_n  (i_SPI_CS_n),
      .i_RX_DV     (i_RX_DV),
      .i_RX_Byte   (i_RX_Byte),
      .o_TX_DV     (o_TX_DV),
      .o_TX_Byte   (o_TX_Byte),
      .o_Reg_Wr    (o_Reg_Wr),
      .o_Reg_Rd    (o_Reg_Rd),
      .o_Reg_Addr  (o_Reg_Addr),
      .o_Reg_WData (o_Reg_WData),
      .i_Reg_RData (i_Reg_RData),
      .o_Busy      (o_Busy),
      .o_Overrun   (o_Overrun),
      .o_State     (o_State)
   );

   // ---------------- register file model and bus monitor ----------------
   logic [7:0]  mem [128];
   bit          rd_hold = 1'b0;
   logic [14:0] wr_log [$];
   logic [6:0]  rd_log [$];
   logic [7:0]  tx_log [$];

   // Read data is valid for exactly the cycle after o_Reg_Rd, junk otherwise
   always @(negedge clk) begin
      if (o_Reg_Rd) begin
         i_Reg_RData = mem[o_Reg_Addr];
         rd_hold = 1'b1;
      end else if (rd_hold) begin
         rd_hold = 1'b0;
      end else begin
         i_Reg_RData = 8'($urandom);
      end
      if (!i_Rst) begin
         if (o_Reg_Wr) wr_log.push_back({o_Reg_Addr, o_Reg_WData});
         if (o_Reg_Rd) rd_log.push_back(o_Reg_Addr);
         if (o_TX_DV)  tx_log.push_back(o_TX_Byte);
      end
   end

   // ---------------- scoreboard ----------------
   int n_pass = 0;
   int n_total = 0;
   logic [14:0] exp_wr_q [$];
   logic [6:0]  exp_rd_q [$];
   logic [7:0]  exp_tx_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic compare_logs(input string tag);
      chk({tag, " wr_count"}, wr_log.size(), exp_wr_q.size());
      for (int i = 0; i < wr_log.size() && i < exp_wr_q.size(); i++)
         chk($sformatf("%s wr%0d", tag, i), wr_log[i], exp_wr_q[i]);
      chk({tag, " rd_count"}, rd_log.size(), exp_rd_q.size());
      for (int i = 0; i < rd_log.size() && i < exp_rd_q.size(); i++)
         chk($sformatf("%s rd%0d", tag, i), rd_log[i], exp_rd_q[i]);
      chk({tag, " tx_count"}, tx_log.size(), exp_tx_q.size());
      for (int i = 0; i < tx_log.size() && i < exp_tx_q.size(); i++)
         chk($sformatf("%s tx%0d", tag, i), tx_log[i], exp_tx_q[i]);
   endtask

   function automatic int next_a(input int a);
      return AUTOINC ? (a + 1) % 128 : a;
   endfunction

   // Transaction-level model: what a whole CS window should produce
   logic [7:0] txn_b [8];
   task automatic build_exp(input logic [7:0] cmd, input int n);
      int a;
      a = int'(cmd[6:0]);
      exp_wr_q.delete(); exp_rd_q.delete(); exp_tx_q.delete();
      if (!cmd[7]) begin
         for (int i = 0; i < n; i++) begin
            exp_wr_q.push_back({7'(a), txn_b[i]});
            a = next_a(a);
         end
      end else begin
         for (int i = 0; i <= n; i++) begin
            exp_rd_q.push_back(7'(a));
            exp_tx_q.push_back(mem[a]);
            a = next_a(a);
         end
      end
      exp_tx_q.push_back(STATUS);
   endtask

   // ---------------- driver tasks ----------------
   task automatic cs_low();
      @(posedge clk); #1 i_SPI_CS_n = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic cs_high();
      @(posedge clk); #1 i_SPI_CS_n = 1'b1;
      repeat (6) @(posedge clk);
   endtask

   // Returns 1 ns after the edge that sampled the byte
   task automatic pulse_byte(input logic [7:0] b);
      @(posedge clk); #1 i_RX_DV = 1'b1; i_RX_Byte = b;
      @(posedge clk); #1 i_RX_DV = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      pulse_byte(b);
      repeat (8) @(posedge clk);
   endtask

   task automatic run_txn(input logic [7:0] cmd, input int n);
      wr_log.delete(); rd_log.delete(); tx_log.delete();
      cs_low();
      #1;
      chk("busy_in_txn", 32'(o_Busy), 32'd1);
      chk("miso_cmd_status", 32'(o_TX_Byte), 32'(STATUS));
      send_byte(cmd);
      for (int i = 0; i < n; i++) send_byte(txn_b[i]);
      cs_high();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " tx_dv"},   32'(o_TX_DV), 0);
      chk({tag, " tx_byte"}, 32'(o_TX_Byte), 32'(STATUS));
      chk({tag, " reg_wr"},  32'(o_Reg_Wr), 0);
      chk({tag, " reg_rd"},  32'(o_Reg_Rd), 0);
      chk({tag, " addr"},    32'(o_Reg_Addr), 0);
      chk({tag, " wdata"},   32'(o_Reg_WData), 0);
      chk({tag, " busy"},    32'(o_Busy), 0);
      chk({tag, " overrun"}, 32'(o_Overrun), 0);
      chk({tag, " state"},   32'(o_State), 32'(ST_IDLE));
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [7:0]       cmd;
      int               n;
      logic [1:0][7:0]  b;
      int               cnt;
      logic [2:0][6:0]  a;
      logic [2:0][7:0]  d;
   } vec_t;

   function automatic vec_t mk(input logic [7:0] cmd, input int n,
                               input logic [7:0] b0, input logic [7:0] b1, input int cnt,
                               input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                               input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
      vec_t v;
      v.cmd = cmd; v.n = n; v.b[0] = b0; v.b[1] = b1; v.cnt = cnt;
      v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
      return v;
   endfunction

   vec_t tbl [6];

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      mem[7'h00] = 8'h18; mem[7'h05] = 8'h3C; mem[7'h06] = 8'h4D;
      mem[7'h07] = 8'h5E; mem[7'h10] = 8'h77; mem[7'h7F] = 8'h81;

      // write burst, read burst, wrap, abort, read wrap, single read
      tbl[0] = mk(8'h10, 2, 8'h11, 8'h22, 2, 7'h10, AUTOINC ? 7'h11 : 7'h10, 7'h00,
                  8'h11, 8'h22, 8'h00);
      tbl[1] = mk(8'h85, 2, 8'h00, 8'h00, 3, 7'h05, AUTOINC ? 7'h06 : 7'h05, AUTOINC ? 7'h07 : 7'h05,
                  8'h3C, AUTOINC ? 8'h4D : 8'h3C, AUTOINC ? 8'h5E : 8'h3C);
      tbl[2] = mk(8'h7F, 2, 8'hA1, 8'hB2, 2, 7'h7F, AUTOINC ? 7'h00 : 7'h7F, 7'h00,
                  8'hA1, 8'hB2, 8'h00);
      tbl[3] = mk(8'h20, 0, 8'h00, 8'h00, 0, 7'h00, 7'h00, 7'h00, 8'h00, 8'h00, 8'h00);
      tbl[4] = mk(8'hFF, 1, 8'h00, 8'h00, 2, 7'h7F, AUTOINC ? 7'h00 : 7'h7F, 7'h00,
                  8'h81, AUTOINC ? 8'h18 : 8'h81, 8'h00);
      tbl[5] = mk(8'h90, 0, 8'h00, 8'h00, 1, 7'h10, 7'h00, 7'h00, 8'h77, 8'h00, 8'h00);

      // ---- reset values and post-reset status preload ----
      repeat (3) @(posedge clk);
      #1 check_reset_values("reset");
      i_Rst = 1'b0;
      @(posedge clk); #1;
      chk("init_tx_dv", 32'(o_TX_DV), 1);
      chk("init_tx_byte", 32'(o_TX_Byte), 32'(STATUS));
      @(posedge clk); #1;
      chk("init_tx_dv_single", 32'(o_TX_DV), 0);

      // ---- table-driven transactions ----
      for (int t = 0; t < 6; t++) begin
         txn_b[0] = tbl[t].b[0];
         txn_b[1] = tbl[t].b[1];
         run_txn(tbl[t].cmd, tbl[t].n);
         exp_wr_q.delete(); exp_rd_q.delete(); exp_tx_q.delete();
         for (int i = 0; i < tbl[t].cnt; i++) begin
            if (tbl[t].cmd[7]) begin
               exp_rd_q.push_back(tbl[t].a[i]);
               exp_tx_q.push_back(tbl[t].d[i]);
            end else begin
               exp_wr_q.push_back({tbl[t].a[i], tbl[t].d[i]});
            end
         end
         exp_tx_q.push_back(STATUS);
         compare_logs($sformatf("tbl%0d", t));
         chk($sformatf("tbl%0d idle", t), 32'(o_State), 32'(ST_IDLE));
         chk($sformatf("tbl%0d busy_off", t), 32'(o_Busy), 0);
      end

      // ---- write latency: strobe exactly one cycle after the byte ----
      cs_low();
      send_byte(8'h30);
      pulse_byte(8'h99);
      chk("wr_lat strobe", 32'(o_Reg_Wr), 1);
      chk("wr_lat addr", 32'(o_Reg_Addr), 32'h30);
      chk("wr_lat data", 32'(o_Reg_WData), 32'h99);
      @(posedge clk); #1;
      chk("wr_lat single", 32'(o_Reg_Wr), 0);
      cs_high();

      // ---- read latency: Rd +1, TX load +3 after the command byte ----
      cs_low();
      pulse_byte(8'h85);
      chk("rd_lat strobe", 32'(o_Reg_Rd), 1);
      chk("rd_lat addr", 32'(o_Reg_Addr), 32'h05);
      chk("rd_lat tx_early", 32'(o_TX_DV), 0);
      @(posedge clk); #1;
      chk("rd_lat single", 32'(o_Reg_Rd), 0);
      chk("rd_lat tx_early2", 32'(o_TX_DV), 0);
      @(posedge clk); #1;
      chk("rd_lat tx_dv", 32'(o_TX_DV), 1);
      chk("rd_lat tx_byte", 32'(o_TX_Byte), 32'h3C);
      repeat (6) @(posedge clk);
      cs_high();

      // ---- CS rise in the same cycle as a data byte: CS wins ----
      cs_low();
      send_byte(8'h40);
      wr_log.delete();
      @(posedge clk); #1 i_SPI_CS_n = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 i_RX_DV = 1'b1; i_RX_Byte = 8'h5A;
      @(posedge clk); #1 i_RX_DV = 1'b0;
      chk("cs_win no_wr", 32'(o_Reg_Wr), 0);
      chk("cs_win tx_dv", 32'(o_TX_DV), 1);
      chk("cs_win tx_byte", 32'(o_TX_Byte), 32'(STATUS));
      chk("cs_win state", 32'(o_State), 32'(ST_IDLE));
      repeat (4) @(posedge clk);
      chk("cs_win wr_log", wr_log.size(), 0);

      // ---- randomized transactions against the model ----
      for (int t = 0; t < 24; t++) begin
         logic [7:0] cmd;
         int n;
         cmd = 8'($urandom_range(0, 255));
         n = $urandom_range(0, 4);
         for (int i = 0; i < n; i++) txn_b[i] = 8'($urandom);
         build_exp(cmd, n);
         run_txn(cmd, n);
         compare_logs($sformatf("rnd%0d cmd=%02h", t, cmd));
      end
      chk("no_overrun_yet", 32'(o_Overrun), 0);

      // ---- overrun: byte arrives while the read is pending ----
      cs_low();
      pulse_byte(8'h85);
      i_RX_DV = 1'b1; i_RX_Byte = 8'hEE;
      @(posedge clk); #1 i_RX_DV = 1'b0;
      chk("overrun set", 32'(o_Overrun), 1);
      repeat (6) @(posedge clk);
      cs_high();
      txn_b[0] = 8'h01;
      run_txn(8'h12, 1);
      chk("overrun sticky", 32'(o_Overrun), 1);

      // ---- reset while the read data is being fetched ----
      cs_low();
      pulse_byte(8'h86);
      @(posedge clk); #1;
      chk("midrd in_wait", 32'(o_State), 32'(ST_RD_WAIT));
      i_Rst = 1'b1;
      @(posedge clk); #1;
      check_reset_values("midrd");
      i_Rst = 1'b0;
      @(posedge clk); #1;
      chk("midrd preload", 32'(o_TX_DV), 1);
      chk("midrd preload_byte", 32'(o_TX_Byte), 32'(STATUS));
      cs_high();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Hard time limit so the bench always terminates
   initial begin
      #2000000;
      n_total++;
      $display("FAIL timeout: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
